grid_reader: RTL and testbench

GRID_READER -- requirements
Module: grid_reader

---
 rtl/grid_pkg.sv | 48 ++++
 rtl/grid_reader_onehot_decode.sv | 33 +++
 rtl/grid_reader.sv | 157 +++++++++++++++
 tb/tb_grid_reader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared grid geometry, read-order selector and beat-to-coordinate mapping.
package grid_pkg;

  localparam int GRID_ORD  = 3;
  localparam int GRID_LEN  = GRID_ORD * GRID_ORD;
  localparam int GRID_AREA = GRID_LEN * GRID_LEN;
  localparam int VALW      = $clog2(GRID_LEN + 1);
  localparam int RCW       = $clog2(GRID_LEN);
  localparam int CNTW      = $clog2(GRID_AREA);

  typedef enum logic {
    ROW_MAJOR = 1'b0,
    BLK_MAJOR = 1'b1
  } readorder_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_LOAD      = 2'd2,
    ST_STREAM    = 2'd3
  } rd_state_t;

  typedef struct packed {
    logic [RCW-1:0] row;
    logic [RCW-1:0] col;
  } coord_t;

  // Map a beat index to the grid tile it carries for the selected order.
  // Divisors are all elaboration-time constants.
  function automatic coord_t beat_coord(readorder_t order, logic [CNTW-1:0] k);
    int     kk;
    int     b;
    int     i;
    coord_t c;
    kk = int'(k);
    b  = kk / GRID_LEN;
    i  = kk % GRID_LEN;
    if (order == ROW_MAJOR) begin
      c.row = RCW'(b);
      c.col = RCW'(i);
    end else begin
      c.row = RCW'((b / GRID_ORD) * GRID_ORD + i / GRID_ORD);
      c.col = RCW'((b % GRID_ORD) * GRID_ORD + i % GRID_ORD);
    end
    return c;
  endfunction

endpackage

// File: rtl/grid_reader_onehot_decode.sv
// One-hot tile decoder: single set bit j -> j+1, empty -> 0, multi-hot -> 0 with error.
module onehot_decode
  import grid_pkg::*;
#(
  parameter int N  = GRID_LEN,
  parameter int VW = VALW
) (
  input  logic [N-1:0]  onehot_i,
  output logic [VW-1:0] value_o,
  output logic          error_o
);

  logic          seen;
  logic          multi;
  logic [VW-1:0] idx;

  // Scan all bits; a second set bit marks the tile as malformed.
  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    idx   = '0;
    for (int j = 0; j < N; j++) begin
      if (onehot_i[j]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
        idx  = VW'(j + 1);
      end
    end
    value_o = multi ? '0 : idx;
    error_o = multi;
  end

endmodule

// File: rtl/grid_reader.sv
// Solution reader: waits for a finished grid, snapshots it and streams
// one decoded tile per beat over a valid/ready interface.
module grid_reader
  import grid_pkg::*;
#(
  parameter readorder_t ORDER = ROW_MAJOR
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          grid_done,
  input  logic                          grid_success,
  input  logic [GRID_AREA*GRID_LEN-1:0] values,
  input  logic                          rq_start,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [VALW-1:0]               out_value,
  output logic [RCW-1:0]                out_row,
  output logic [RCW-1:0]                out_col,
  output logic                          out_last,
  output logic                          out_error,
  output logic                          busy,
  output logic                          rq_fail
);

  rd_state_t                     state_q, state_d;
  logic [GRID_AREA*GRID_LEN-1:0] snap_q;
  logic                          snap_en;
  logic [CNTW-1:0]               cnt_q, cnt_d;
  logic                          vld_q, vld_d;
  logic [VALW-1:0]               value_q, value_d;
  logic                          error_q, error_d;
  logic [RCW-1:0]                row_q, row_d;
  logic [RCW-1:0]                col_q, col_d;
  logic                          last_q, last_d;
  logic                          fail_q, fail_d;

  logic [CNTW-1:0]               nxt_idx;
  coord_t                        nxt_crd;
  int                            tile_idx;
  logic [GRID_LEN-1:0]           tile_bits;
  logic [VALW-1:0]               dec_value;
  logic                          dec_error;

  // Index and tile of the beat that would be loaded next (beat 0 in LOAD).
  always_comb begin
    nxt_idx   = (state_q == ST_LOAD) ? '0 : cnt_q + 1'b1;
    nxt_crd   = beat_coord(ORDER, nxt_idx);
    tile_idx  = int'(nxt_crd.row) * GRID_LEN + int'(nxt_crd.col);
    tile_bits = snap_q[tile_idx*GRID_LEN +: GRID_LEN];
  end

  onehot_decode #(
    .N  (GRID_LEN),
    .VW (VALW)
  ) u_dec (
    .onehot_i (tile_bits),
    .value_o  (dec_value),
    .error_o  (dec_error)
  );

  // Next-state logic and output-register loading.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    value_d = value_q;
    error_d = error_q;
    row_d   = row_q;
    col_d   = col_q;
    last_d  = last_q;
    fail_d  = 1'b0;
    snap_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rq_start) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (grid_done) begin
          if (grid_success) begin
            state_d = ST_LOAD;
            snap_en = 1'b1;
          end else begin
            state_d = ST_IDLE;
            fail_d  = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        state_d = ST_STREAM;
        cnt_d   = '0;
        vld_d   = 1'b1;
        value_d = dec_value;
        error_d = dec_error;
        row_d   = nxt_crd.row;
        col_d   = nxt_crd.col;
        last_d  = (nxt_idx == CNTW'(GRID_AREA - 1));
      end
      ST_STREAM: begin
        if (vld_q && out_ready) begin
          if (cnt_q == CNTW'(GRID_AREA - 1)) begin
            state_d = ST_IDLE;
            vld_d   = 1'b0;
            last_d  = 1'b0;
          end else begin
            cnt_d   = nxt_idx;
            value_d = dec_value;
            error_d = dec_error;
            row_d   = nxt_crd.row;
            col_d   = nxt_crd.col;
            last_d  = (nxt_idx == CNTW'(GRID_AREA - 1));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and beat registers; reset drops any partial stream.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      value_q <= '0;
      error_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      value_q <= value_d;
      error_q <= error_d;
      row_q   <= row_d;
      col_q   <= col_d;
      last_q  <= last_d;
      fail_q  <= fail_d;
    end
  end

  // Snapshot of the finished grid; stream reads only from here.
  always_ff @(posedge clock) begin
    if (snap_en) snap_q <= values;
  end

  assign out_valid = vld_q;
  assign out_value = value_q;
  assign out_error = error_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = last_q;
  assign busy      = (state_q != ST_IDLE);
  assign rq_fail   = fail_q;

endmodule

// File: tb/tb_grid_reader.sv
module tb_grid_reader;
  import grid_pkg::*;

  logic                          clock = 1'b0;
  logic                          reset = 1'b1;
  logic                          grid_done = 1'b0;
  logic                          grid_success = 1'b0;
  logic                          rq_start = 1'b0;
  logic                          out_ready = 1'b0;
  logic [GRID_AREA*GRID_LEN-1:0] values = '0;

  logic            r_valid, r_last, r_error, r_busy, r_fail;
  logic [VALW-1:0] r_value;
  logic [RCW-1:0]  r_row, r_col;
  logic            b_valid, b_last, b_error, b_busy, b_fail;
  logic [VALW-1:0] b_value;
  logic [RCW-1:0]  b_row, b_col;

  int checks = 0;
  int errors = 0;
  logic [8:0] grid_m [GRID_AREA];

  always #5 clock = ~clock;

  grid_reader #(.ORDER(ROW_MAJOR)) dut_row (
    .clock(clock), .reset(reset), .grid_done(grid_done), .grid_success(grid_success),
    .values(values), .rq_start(rq_start), .out_ready(out_ready),
    .out_valid(r_valid), .out_value(r_value), .out_row(r_row), .out_col(r_col),
    .out_last(r_last), .out_error(r_error), .busy(r_busy), .rq_fail(r_fail));

  grid_reader #(.ORDER(BLK_MAJOR)) dut_blk (
    .clock(clock), .reset(reset), .grid_done(grid_done), .grid_success(grid_success),
    .values(values), .rq_start(rq_start), .out_ready(out_ready),
    .out_valid(b_valid), .out_value(b_value), .out_row(b_row), .out_col(b_col),
    .out_last(b_last), .out_error(b_error), .busy(b_busy), .rq_fail(b_fail));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference tile position for beat k, straight from the read-order rules.
  function automatic int ref_row(input bit blk, input int k);
    int b, i;
    b = k / 9; i = k % 9;
    return blk ? (b / 3) * 3 + i / 3 : b;
  endfunction

  function automatic int ref_col(input bit blk, input int k);
    int b, i;
    b = k / 9; i = k % 9;
    return blk ? (b % 3) * 3 + i % 3 : i;
  endfunction

  function automatic int ref_val(input logic [8:0] v);
    int n;
    n = $countones(v);
    if (n != 1) return 0;
    for (int j = 0; j < 9; j++) if (v[j]) return j + 1;
    return 0;
  endfunction

  task automatic check_beat(input string p, input bit blk, input int k,
                            input logic [31:0] val, input logic [31:0] row,
                            input logic [31:0] col, input logic [31:0] last,
                            input logic [31:0] err);
    int rr, cc;
    logic [8:0] v;
    rr = ref_row(blk, k);
    cc = ref_col(blk, k);
    v  = grid_m[rr*9 + cc];
    chk($sformatf("%s_row_k%0d", p, k), row, rr);
    chk($sformatf("%s_col_k%0d", p, k), col, cc);
    chk($sformatf("%s_val_k%0d", p, k), val, ref_val(v));
    chk($sformatf("%s_err_k%0d", p, k), err, ($countones(v) > 1) ? 1 : 0);
    chk($sformatf("%s_last_k%0d", p, k), last, (k == 80) ? 1 : 0);
  endtask

  task automatic pack_values();
    for (int t = 0; t < GRID_AREA; t++) values[t*GRID_LEN +: GRID_LEN] = grid_m[t];
  endtask

  // Issue a request and present a finished grid; ends just after the edge
  // that samples grid_done, with the snapshot taken and values scrambled.
  task automatic request(input bit success);
    @(posedge clock); #1 rq_start = 1'b1;
    @(posedge clock); #1 rq_start = 1'b0;
    @(negedge clock);
    chk("busy_wait", r_busy, 1);
    @(posedge clock); #1;
    repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
    chk("no_beat_wait", r_valid, 0);
    grid_done = 1'b1;
    grid_success = success;
    @(posedge clock); #1;
    for (int t = 0; t < GRID_AREA; t++) values[t*GRID_LEN +: GRID_LEN] = 9'($urandom);
  endtask

  task automatic run_stream(input int ready_pct, input int stop_k, output int got);
    int k, cyc;
    bit first;
    k = 0; cyc = 0; first = 1'b1;
    @(negedge clock);
    chk("valid_after_done", r_valid, 0);
    while (k < stop_k && cyc < 1000) begin
      @(posedge clock); #1;
      out_ready = ($urandom_range(0, 99) < ready_pct);
      @(negedge clock);
      if (first) begin
        chk("first_beat_lat", r_valid, 1);
        first = 1'b0;
      end
      if (r_valid) begin
        chk("blk_valid", b_valid, 1);
        check_beat("row", 1'b0, k, r_value, r_row, r_col, r_last, r_error);
        check_beat("blk", 1'b1, k, b_value, b_row, b_col, b_last, b_error);
        if (k == 3)  begin chk("blk_b3_row", b_row, 1);  chk("blk_b3_col", b_col, 0); end
        if (k == 9)  begin chk("blk_b9_row", b_row, 0);  chk("blk_b9_col", b_col, 3); end
        if (k == 80) begin chk("blk_b80_row", b_row, 8); chk("blk_b80_col", b_col, 8); end
        if (out_ready) k++;
      end
      cyc++;
    end
    got = k;
    chk("beats_delivered", got, stop_k);
  endtask

  task automatic finish_stream();
    @(posedge clock); #1;
    @(negedge clock);
    chk("end_valid", r_valid, 0);
    chk("end_busy", r_busy, 0);
    chk("end_blk_valid", b_valid, 0);
    grid_done = 1'b0;
    grid_success = 1'b0;
  endtask

  task automatic random_grid();
    int r;
    for (int t = 0; t < GRID_AREA; t++) begin
      r = $urandom_range(0, 11);
      if (r < 9)       grid_m[t] = 9'(1 << r);
      else if (r == 9) grid_m[t] = '0;
      else             grid_m[t] = 9'($urandom);
    end
  endtask

  initial begin
    int got;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", r_valid, 0);
    chk("rst_busy", r_busy, 0);
    chk("rst_fail", r_fail, 0);
    chk("rst_last", r_last, 0);
    chk("rst_error", r_error, 0);
    chk("rst_value", r_value, 0);
    chk("rst_row", r_row, 0);
    chk("rst_col", r_col, 0);
    #1 reset = 1'b0;

    // Known valid solution, full throughput.
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        grid_m[r*9 + c] = 9'(1 << ((r * 3 + r / 3 + c) % 9));
    pack_values();
    out_ready = 1'b1;
    request(1'b1);
    run_stream(100, 81, got);
    finish_stream();

    // Grid finished without success.
    request(1'b0);
    @(negedge clock);
    chk("fail_pulse", r_fail, 1);
    chk("fail_busy", r_busy, 0);
    chk("fail_valid", r_valid, 0);
    @(negedge clock);
    chk("fail_pulse_end", r_fail, 0);
    chk("fail_no_beat", r_valid, 0);
    grid_done = 1'b0;
    grid_success = 1'b0;

    // Malformed tiles with random stalls.
    random_grid();
    grid_m[5] = 9'b000000101;
    grid_m[6] = 9'b000000000;
    pack_values();
    request(1'b1);
    run_stream(50, 81, got);
    finish_stream();

    // More random grids under stalls.
    for (int n = 0; n < 3; n++) begin
      random_grid();
      pack_values();
      request(1'b1);
      run_stream(50, 81, got);
      finish_stream();
    end

    // Reset in the middle of a stream, then a fresh request.
    random_grid();
    pack_values();
    request(1'b1);
    run_stream(100, 40, got);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("midrst_valid", r_valid, 0);
    chk("midrst_busy", r_busy, 0);
    chk("midrst_last", r_last, 0);
    chk("midrst_value", r_value, 0);
    #1 reset = 1'b0;
    grid_done = 1'b0;
    grid_success = 1'b0;
    pack_values();
    request(1'b1);
    run_stream(100, 81, got);
    finish_stream();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
